enc_sel_ctrl: RTL and testbench
===============================

Name: enc_sel_ctrl

Overview:
Adaptive scheduler for the low-power bus-encoder bank: normal, bus-invert, transition-based, Gray and T0 encoders.
- Accumulates each encoder's per-cycle transition count over a fixed window of valid cycles.
- Picks the cheapest encoder, applying hysteresis against the current one.
- Sequences the switch of the shared encoded bus with a req/ack handshake to the decoder side.
- Sits between the encoder bank's transition-count outputs and the bus output mux select.

Parameters:
N_ENC, 5, number of candidate encoders (index 0..N_ENC-1)
CW, 4, width of one per-cycle transition count (max 9 for a 9-bit bus)
WIN_LOG2, 6, log2 of window length in valid cycles (default window = 64)
HYST, 8, minimum accumulated-cost improvement required to switch
RESET_SEL, 0, encoder index selected after reset
ACC_W, CW+WIN_LOG2, accumulator width (derived; must not be overridden)

Ports:
ck  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
en  input  1  sample valid; tc_in is accumulated only when high
tc_in  input  N_ENC*CW  packed per-cycle transition counts, encoder i at [i*CW +: CW]
sel  output  3  encoder currently driving the bus
sw_req  output  1  switch request to the decoder side
sw_target  output  3  requested encoder index; valid while sw_req=1
sw_ack  input  1  decoder has accepted sw_target
win_done  output  1  one-cycle pulse when a window closes
best_idx  output  3  winner of the last decision
best_cost  output  ACC_W  accumulated cost of best_idx in the last window

Behaviour:
Ck and reset (already decided)
- One clock, ck. Reset rst is synchronous and active-high.
- Reset, including when asserted mid-operation in any state:
  - state=ACCUM, all accumulators and win_cnt = 0
  - sel = RESET_SEL
  - sw_req, win_done, sw_target, best_idx, best_cost all = 0

ACCUM
- Each cycle with en=1: acc[i] += tc_in[i] for every i, and win_cnt++.
- On the en=1 cycle where win_cnt = 2^WIN_LOG2-1 (that sample is included), go to SCAN next cycle.
- Cycles with en=0 change nothing.

SCAN (N_ENC cycles)
- win_done=1 in the first SCAN cycle only.
- Scan index k runs 0..N_ENC-1, one per cycle.
- Running minimum is updated only on strictly smaller cost, so ties resolve to the lowest index.
- After k=N_ENC-1:
  - best_idx and best_cost are registered.
  - If acc[best]+HYST < acc[sel] (strict), go to SWITCH; otherwise go to ACCUM.
  - Either way, accumulators and win_cnt are cleared.

SWITCH
- sw_req=1 and sw_target=best_idx, both held stable until sw_ack=1 is sampled.
- The cycle after ack is sampled: sel=sw_target, sw_req=0, return to ACCUM.
- sw_ack is sampled only in SWITCH; it is ignored in all other states.
- An ack in the first SWITCH cycle is valid, giving minimum switch latency of 2 cycles from SWITCH entry. There is no timeout.

Common rules
- en is ignored in SCAN and SWITCH; those samples are dropped and are not counted toward the next window.
- Accumulator width rule: ACC_W bits hold the worst case WIN*(2^CW-1) without overflow. No saturation logic is needed.
- sel never changes except via SWITCH completion or reset.

Optional Feature:
ENC_SEL_STATS_EN
- Defined: adds output sw_count (16 bits), incremented on each completed switch, saturating at 16'hFFFF and cleared by rst. Also adds output sel_cost (ACC_W bits) = acc[sel] captured at the end of the last SCAN.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
Package enc_sel_pkg:
- state enum {ACCUM, SCAN, SWITCH}
- encoder index constants ENC_NORM=0, ENC_INV=1, ENC_TRAN=2, ENC_GRAY=3, ENC_T0=4
- width function for ACC_W
Sub-module enc_cost_acc:
- Bank of N_ENC accumulators with clear, enable and indexed read port used by SCAN.
- FSM, argmin and handshake stay in enc_sel_ctrl.

Test Plan:
1. Reset: rst=1 for 2 cycles mid-SWITCH, then release. Next cycle: sw_req=0, sel=RESET_SEL, state ACCUM, win_cnt restarts from 0.
2. No switch needed: WIN_LOG2=2, enc0 tc=4, all others 5, en=1 for 4 cycles. Response: win_done pulses, best_idx=0, best_cost=16, sw_req stays 0.
3. Switch:
   - Stimulus: WIN_LOG2=2, sel=0 with tc=4, enc3 tc=1, others 9; sw_ack raised 3 cycles after sw_req.
   - Response: acc 4 vs 16, so sw_req=1 with sw_target=3, held 3 cycles; sel=3 the cycle after ack.
4. Hysteresis and ties:
   - enc2 acc=10 vs sel acc=16: 10+8 is not < 16, so no switch.
   - enc1 and enc2 both acc=0 with sel acc=16: sw_target=1.
5. en gaps: en toggling 1,0,1,0 over 8 cycles with WIN_LOG2=2. Window closes only after the 4th en=1 cycle; sw_ack pulses outside SWITCH have no effect.
6. ENC_SEL_STATS_EN: 3 consecutive switches give sw_count=3; sel_cost equals acc[sel] from the last window.

Source files
------------

// File: rtl/enc_sel_pkg.sv
// enc_sel_pkg: shared state encoding, encoder indices and accumulator width helper for enc_sel_ctrl
package enc_sel_pkg;
  typedef enum logic [1:0] {ACCUM, SCAN, SWITCH} state_t;
  localparam logic [2:0] ENC_NORM = 3'd0;
  localparam logic [2:0] ENC_INV = 3'd1;
  localparam logic [2:0] ENC_TRAN = 3'd2;
  localparam logic [2:0] ENC_GRAY = 3'd3;
  localparam logic [2:0] ENC_T0 = 3'd4;
  function automatic int acc_width(input int cw, input int win_log2);
    return cw + win_log2;
  endfunction
endpackage

// File: rtl/enc_cost_acc.sv
// enc_cost_acc: bank of per-encoder cost accumulators with clear, enable and two indexed read ports
module enc_cost_acc import enc_sel_pkg::*; #(
  parameter int N_ENC = 5,
  parameter int CW = 4,
  parameter int ACC_W = acc_width(4, 6)
) (
  input  logic                   ck,
  input  logic                   clr,
  input  logic                   en,
  input  logic [N_ENC*CW-1:0]    tc_in,
  input  logic [2:0]             ra,
  input  logic [2:0]             rb,
  output logic [ACC_W-1:0]       qa,
  output logic [ACC_W-1:0]       qb
);
  logic [ACC_W-1:0] acc [N_ENC];
  always_ff @(posedge ck)
    for (int i = 0; i < N_ENC; i++)
      if (clr) acc[i] <= '0;
      else if (en) acc[i] <= acc[i] + ACC_W'(tc_in[i*CW +: CW]);
  assign qa = acc[ra];
  assign qb = acc[rb];
endmodule

// File: rtl/enc_sel_ctrl.sv
// enc_sel_ctrl: windowed cost scan, hysteretic encoder choice and req/ack bus switch sequencing
// Optional ENC_SEL_STATS_EN adds sw_count and sel_cost outputs.
module enc_sel_ctrl import enc_sel_pkg::*; #(
  parameter int N_ENC = 5,
  parameter int CW = 4,
  parameter int WIN_LOG2 = 6,
  parameter int HYST = 8,
  parameter int RESET_SEL = ENC_NORM,
  localparam int ACC_W = acc_width(CW, WIN_LOG2)
) (
  input  logic                ck,
  input  logic                rst,
  input  logic                en,
  input  logic [N_ENC*CW-1:0] tc_in,
  output logic [2:0]          sel,
  output logic                sw_req,
  output logic [2:0]          sw_target,
  input  logic                sw_ack,
  output logic                win_done,
  output logic [2:0]          best_idx,
  output logic [ACC_W-1:0]    best_cost
`ifdef ENC_SEL_STATS_EN
  ,
  output logic [15:0]         sw_count,
  output logic [ACC_W-1:0]    sel_cost
`endif
);
  state_t state, state_n;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [2:0] k, min_idx, best_i;
  logic [ACC_W-1:0] min_cost, qa, qb, best_c;
  logic scan_last, take, do_switch;
  enc_cost_acc #(.N_ENC(N_ENC), .CW(CW), .ACC_W(ACC_W)) u_acc (
    .ck(ck),
    .clr(rst || scan_last),
    .en(state == ACCUM && en),
    .tc_in(tc_in),
    .ra(k),
    .rb(sel),
    .qa(qa),
    .qb(qb)
  );
  // strict less-than keeps the lowest index on ties; k==0 seeds the running minimum
  always_comb begin
    scan_last = state == SCAN && k == 3'(N_ENC - 1);
    take = k == 3'd0 || qa < min_cost;
    best_i = take ? k : min_idx;
    best_c = take ? qa : min_cost;
    do_switch = {1'b0, best_c} + (ACC_W + 1)'(HYST) < {1'b0, qb};
    win_done = state == SCAN && k == 3'd0;
    sw_req = state == SWITCH;
    state_n = state == ACCUM ? ((en && &win_cnt) ? SCAN : ACCUM)
            : state == SCAN ? (scan_last ? (do_switch ? SWITCH : ACCUM) : SCAN)
            : (sw_ack ? ACCUM : SWITCH);
  end
  always_ff @(posedge ck)
    state <= rst ? ACCUM : state_n;
  always_ff @(posedge ck)
    if (rst) begin
      win_cnt <= '0;
      k <= '0;
      min_idx <= '0;
      min_cost <= '0;
      sel <= 3'(RESET_SEL);
      sw_target <= '0;
      best_idx <= '0;
      best_cost <= '0;
    end else begin
      if (state == ACCUM && en) win_cnt <= win_cnt + WIN_LOG2'(1);
      if (state == SCAN) begin
        k <= scan_last ? 3'd0 : k + 3'd1;
        min_idx <= best_i;
        min_cost <= best_c;
      end
      if (scan_last) begin
        best_idx <= best_i;
        best_cost <= best_c;
        sw_target <= best_i;
      end
      if (state == SWITCH && sw_ack) sel <= sw_target;
    end
`ifdef ENC_SEL_STATS_EN
  always_ff @(posedge ck)
    if (rst) begin
      sw_count <= '0;
      sel_cost <= '0;
    end else begin
      if (state == SWITCH && sw_ack && !(&sw_count)) sw_count <= sw_count + 16'd1;
      if (scan_last) sel_cost <= qb;
    end
`endif
endmodule

// File: tb/tb_enc_sel_ctrl.sv
// tb_enc_sel_ctrl: directed windows with queued expected decisions and sel changes, checked by monitors
module tb_enc_sel_ctrl;
  localparam int N_ENC = 5;
  localparam int CW = 4;
  localparam int WL = 2;
  localparam int ACC_W = CW + WL;
  logic ck = 0, rst = 1, en = 0, sw_ack = 0;
  logic [N_ENC*CW-1:0] tc_in = '0;
  logic [2:0] sel, sw_target, best_idx;
  logic sw_req, win_done;
  logic [ACC_W-1:0] best_cost;
`ifdef ENC_SEL_STATS_EN
  logic [15:0] sw_count;
  logic [ACC_W-1:0] sel_cost;
`endif
  typedef struct packed {
    logic [2:0] idx;
    logic [ACC_W-1:0] cost;
    logic req;
  } dec_t;
  dec_t dq[$];
  logic [2:0] sq[$];
  int n_vec = 0, n_fail = 0;
  enc_sel_ctrl #(.N_ENC(N_ENC), .CW(CW), .WIN_LOG2(WL), .HYST(8), .RESET_SEL(0)) dut (
    .ck(ck),
    .rst(rst),
    .en(en),
    .tc_in(tc_in),
    .sel(sel),
    .sw_req(sw_req),
    .sw_target(sw_target),
    .sw_ack(sw_ack),
    .win_done(win_done),
    .best_idx(best_idx),
    .best_cost(best_cost)
`ifdef ENC_SEL_STATS_EN
    ,
    .sw_count(sw_count),
    .sel_cost(sel_cost)
`endif
  );
  always #5 ck = ~ck;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic miss(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: no expected entry or DUT event", name);
  endtask
  function automatic logic [N_ENC*CW-1:0] mk(input int a, b, c, d, e);
    return {4'(e), 4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction
  task automatic exp_dec(input int idx, input int cost, input bit req);
    dec_t e;
    e.idx = 3'(idx);
    e.cost = ACC_W'(cost);
    e.req = req;
    dq.push_back(e);
  endtask
  task automatic win4(input logic [N_ENC*CW-1:0] a, b, c, d);
    logic [N_ENC*CW-1:0] v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      en = 1;
      tc_in = v[i];
      @(posedge ck);
      #1;
    end
    en = 0;
  endtask
  task automatic settle();
    repeat (N_ENC) @(posedge ck);
    #1;
  endtask
  task automatic do_ack(input int delay);
    int t = 0;
    while (!sw_req && t < 20) begin
      @(posedge ck);
      #1;
      t++;
    end
    if (!sw_req) miss("sw_req_timeout");
    else begin
      repeat (delay) @(posedge ck);
      #1;
      sw_ack = 1;
      @(posedge ck);
      #1;
      sw_ack = 0;
      check("sw_req_drop", sw_req, 0);
    end
  endtask
  // decision monitor: best_* are registered at the end of the N_ENC-cycle scan
  initial forever begin
    dec_t e;
    @(negedge ck);
    if (win_done) begin
      repeat (N_ENC) @(negedge ck);
      if (dq.size() == 0) miss("dec_unexpected");
      else begin
        e = dq.pop_front();
        check("best_idx", best_idx, e.idx);
        check("best_cost", best_cost, e.cost);
        check("sw_req", sw_req, e.req);
        if (e.req) check("sw_target", sw_target, e.idx);
      end
    end
  end
  initial begin
    logic [2:0] ps, pt;
    logic pr;
    ps = 0;
    pt = 0;
    pr = 0;
    forever begin
      @(negedge ck);
      if (sel !== ps) begin
        if (sq.size() == 0) miss("sel_unexpected");
        else check("sel", sel, sq.pop_front());
        ps = sel;
      end
      if (sw_req && pr) check("sw_target_hold", sw_target, pt);
      pr = sw_req;
      pt = sw_target;
    end
  end
  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1;
    repeat (2) @(posedge ck);
    #1;
    rst = 0;
    check("rst_sel", sel, 0);
    check("rst_sw_req", sw_req, 0);
    check("rst_win_done", win_done, 0);
    check("rst_best_idx", best_idx, 0);
    check("rst_best_cost", best_cost, 0);
    check("rst_sw_target", sw_target, 0);
    exp_dec(0, 16, 0);
    win4(mk(4, 5, 5, 5, 5), mk(4, 5, 5, 5, 5), mk(4, 5, 5, 5, 5), mk(4, 5, 5, 5, 5));
    settle();
    exp_dec(2, 10, 0);
    win4(mk(4, 5, 3, 5, 5), mk(4, 5, 3, 5, 5), mk(4, 5, 2, 5, 5), mk(4, 5, 2, 5, 5));
    settle();
    exp_dec(2, 8, 0);
    win4(mk(4, 5, 2, 5, 5), mk(4, 5, 2, 5, 5), mk(4, 5, 2, 5, 5), mk(4, 5, 2, 5, 5));
    settle();
    exp_dec(4, 0, 1);
    win4(mk(4, 9, 9, 9, 0), mk(4, 9, 9, 9, 0), mk(4, 9, 9, 9, 0), mk(4, 9, 9, 9, 0));
    settle();
    check("sw_req_pre_rst", sw_req, 1);
    rst = 1;
    repeat (2) @(posedge ck);
    #1;
    rst = 0;
    check("midrst_sw_req", sw_req, 0);
    check("midrst_sel", sel, 0);
    check("midrst_best_idx", best_idx, 0);
    check("midrst_best_cost", best_cost, 0);
    check("midrst_sw_target", sw_target, 0);
    en = 1;
    tc_in = mk(9, 9, 9, 9, 9);
    repeat (2) @(posedge ck);
    #1;
    en = 0;
    rst = 1;
    @(posedge ck);
    #1;
    rst = 0;
    exp_dec(0, 16, 0);
    win4(mk(4, 5, 5, 5, 5), mk(4, 5, 5, 5, 5), mk(4, 5, 5, 5, 5), mk(4, 5, 5, 5, 5));
    settle();
    exp_dec(3, 4, 1);
    sq.push_back(3);
    win4(mk(4, 9, 9, 1, 9), mk(4, 9, 9, 1, 9), mk(4, 9, 9, 1, 9), mk(4, 9, 9, 1, 9));
    settle();
    do_ack(3);
    exp_dec(1, 0, 1);
    sq.push_back(1);
    win4(mk(9, 0, 0, 4, 9), mk(9, 0, 0, 4, 9), mk(9, 0, 0, 4, 9), mk(9, 0, 0, 4, 9));
    settle();
    do_ack(0);
    exp_dec(0, 4, 1);
    sq.push_back(0);
    for (int i = 0; i < 7; i++) begin
      en = (i % 2) == 0;
      sw_ack = !en;
      tc_in = en ? mk(1, 5, 9, 9, 9) : mk(15, 15, 15, 15, 15);
      @(negedge ck);
      check("win_done_early", win_done, 0);
      @(posedge ck);
      #1;
    end
    en = 0;
    sw_ack = 0;
    settle();
    do_ack(1);
    exp_dec(0, 16, 0);
    win4(mk(4, 5, 5, 5, 5), mk(4, 5, 5, 5, 5), mk(4, 5, 5, 5, 5), mk(4, 5, 5, 5, 5));
    settle();
    repeat (2) @(posedge ck);
    #1;
    check("dq_empty", dq.size(), 0);
    check("sq_empty", sq.size(), 0);
    check("final_sel", sel, 0);
`ifdef ENC_SEL_STATS_EN
    check("sw_count", sw_count, 3);
    check("sel_cost", sel_cost, 16);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
